// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the sequence detector.
// Words enter through a valid/ready handshake into a small circular FIFO.
// A two-state shifter streams them out one bit per enabled cycle. The next
// word is loaded on the last-bit edge, so consecutive words leave with no gap.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     bit_en,
  output logic                     out,
  output logic                     out_valid,
  output logic                     word_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] head;
  logic [IW-1:0]    bit_idx;
  logic             push;
  logic             pop;
  logic             last_bit;

  // Bit that sits at the output end of a word for the configured bit order.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Ready depends only on the registered count, so a pop at full cannot
  // open a slot in the same cycle and bit_en never reaches din_ready.
  assign din_ready = rst && (fifo_count < CW'(DEPTH));
  assign push      = din_valid && din_ready;
  assign head      = mem[rd_ptr];
  assign last_bit  = (state == SHIFT) && bit_en && (bit_idx == LAST_IDX);
  assign pop       = (fifo_count != '0) && ((state == IDLE) || last_bit);
  assign shifted   = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};

  // Word storage; contents need no reset because the count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Shifter FSM with registered serial outputs; reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= last_bit;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= head;
            bit_idx   <= '0;
            out       <= lead_bit(head);
            out_valid <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (bit_idx != LAST_IDX) begin
              shreg   <= shifted;
              bit_idx <= bit_idx + 1'b1;
              out     <= lead_bit(shifted);
            end else if (pop) begin
              shreg   <= head;
              bit_idx <= '0;
              out     <= lead_bit(head);
            end else begin
              shreg     <= '0;
              bit_idx   <= '0;
              out       <= 1'b0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the sequence-detector stage. It accepts WIDTH-bit words through a valid/ready handshake and buffers them in a DEPTH-entry word FIFO. It shifts each word out one bit per enabled cycle on `out`, which drives the detector's serial `in` port directly. Back-to-back words stream with no idle cycles between them, so the downstream detector sees a continuous bit stream and can match patterns that straddle a word boundary.

## Interface
- WIDTH, 8, bits per word; must be ≥ 2.
- DEPTH, 4, word FIFO entries; must be a power of 2, ≥ 2.
- MSB_FIRST, 1, bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  word to serialize.
- din_valid  in  1  `din` holds a valid word.
- din_ready  out  1  FIFO can accept a word; a transfer occurs on an edge with `din_valid` and `din_ready` both high.
- bit_en  in  1  advance enable; the current bit is consumed on an edge where `bit_en` is 1.
- out  out  1  current serial bit; 0 whenever `out_valid` is 0.
- out_valid  out  1  `out` carries a valid bit.
- word_done  out  1  one-cycle pulse: the last bit of a word was consumed.
- fifo_count  out  $clog2(DEPTH)+1  words held in the FIFO, excluding the word in the shifter.

## Operation
- Reset value of the FIFO:
  - Circular buffer with write pointer, read pointer and count.
  - Push when `din_valid && din_ready`.
  - `din_ready = rst && (fifo_count < DEPTH)`. `din_ready` has no combinational path from `bit_en`.
  - A pop at full does not make room in the same cycle.
  - Push and pop on the same edge leave `fifo_count` unchanged.
- Shifter FSM:
  - State IDLE; `out_valid` = 0.
    - Transition: if `fifo_count` > 0 at the edge, pop the head word into the shift register, clear `bit_idx`, and go to SHIFT.
  - State SHIFT; `out_valid` = 1.
    - `out` = current bit: shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
    - Edge with `bit_en` = 0: hold everything.
    - Edge with `bit_en` = 1 and `bit_idx` < WIDTH-1: shift by one toward the output end and increment `bit_idx`.
    - Edge with `bit_en` = 1 and `bit_idx` = WIDTH-1 (last bit), with `fifo_count` > 0: pop and load the next word, and stay in SHIFT (zero-gap).
    - Same last-bit edge with `fifo_count` = 0: go to IDLE.
    - Either last-bit case: `word_done` = 1 for the following cycle.
- `bit_idx` width: $clog2(WIDTH). It never exceeds WIDTH-1 and never wraps silently.
- Reset (`rst` = 0, at any time, including mid-word):
  - Immediately clear the FIFO pointers and count, the shift register and `bit_idx`.
  - State = IDLE.
  - `out` = 0, `out_valid` = 0, `word_done` = 0, `fifo_count` = 0, `din_ready` = 0.
  - A partially shifted word is discarded.
  - After `rst` deasserts, `din_ready` = 1 on the first cycle.

## Timing
- Latency: a word accepted at edge k into an empty, idle block is loaded at edge k+1. Its first bit appears on `out` with `out_valid` = 1 in the cycle after k+1.
- With `bit_en` held at 1, a word occupies exactly WIDTH cycles on `out`, and consecutive buffered words are contiguous.
- `fifo_count` updates on the push/pop edge.
- `out`, `out_valid`, `word_done` and `fifo_count` are registered. `din_ready` is derived combinationally from the registered count and `rst`.
- Stall: while `bit_en` = 0, `out` and `out_valid` hold steady for any number of cycles. The FIFO continues to accept words until full.
- Capacity: DEPTH words in the FIFO plus 1 in the shifter.

## Test plan
- Single word, MSB_FIRST=1: push 8'hB5 with `bit_en`=1 throughout.
  - `out` = 1,0,1,1,0,1,0,1 on 8 consecutive cycles, starting the cycle after the load edge.
  - `word_done` pulses once after the 8th bit; then `out_valid`=0 and `out`=0.
- Back-to-back: push 8'hB5 then 8'h5A on consecutive edges.
  - 16 contiguous `out_valid` cycles with no gap: bits 10110101 01011010.
  - Two `word_done` pulses, 8 cycles apart.
- Fill and backpressure: `bit_en`=0 with `din_valid` held high.
  - Exactly 5 words accepted: 1 in the shifter, 4 in the FIFO.
  - Then `din_ready`=0 and `fifo_count`=4, with `out` holding the first bit.
  - Raising `bit_en` drains all 5 words as 40 contiguous bits.
- Mid-word stall: pulse `bit_en` low for 3 cycles after bit 3 of 8'hB5.
  - `out` holds bit 3's value for those 3 extra cycles.
  - The remaining sequence is unchanged and `word_done` is delayed by 3 cycles.
- Reset mid-word: assert `rst`=0 asynchronously (between clock edges) after 4 bits, with 2 words queued.
  - All outputs go to 0 immediately and `fifo_count`=0.
  - After release, a newly pushed 8'hFF serializes cleanly as eight 1s.
- MSB_FIRST=0: push 8'hB5; `out` = 1,0,1,0,1,1,0,1.
